// File: rtl/ppcpu_pkg.sv
// Shared types and constants for the ppcpu hazard/forwarding logic.
package ppcpu_pkg;

  localparam int unsigned REG_AW_DFLT = 5;

  // Stage distances measured from ID.
  localparam int unsigned D_EX  = 1;
  localparam int unsigned D_MEM = 2;
  localparam int unsigned D_WB  = 3;

  // Forward select meaning "take the register file value".
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DFLT-1:0] rw;
    logic                   regwr;
    logic                   load;
  } sb_entry_t;

endpackage

// File: rtl/ppcpu_sb_match.sv
// Per-operand priority matcher: finds the youngest in-flight producer of a source register.
module ppcpu_sb_match
  import ppcpu_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [REG_AW_DFLT-1:0] src_i,
  input  logic                   use_i,
  input  logic                   id_valid_i,
  input  sb_entry_t [NSTAGE:1]   ent_i,
  output logic [SEL_W-1:0]       fwd_o,
  output logic                   load_hit_o
);

  always_comb begin
    fwd_o      = SEL_W'(FWD_RF);
    load_hit_o = 1'b0;
    // Oldest first, so a younger match overwrites an older one.
    for (int d = NSTAGE; d >= 1; d--) begin
      if (ent_i[d].valid && ent_i[d].regwr && (ent_i[d].rw == src_i) &&
          (src_i != '0) && use_i && id_valid_i) begin
        fwd_o      = SEL_W'(d);
        load_hit_o = ent_i[d].load && (d < int'(LOAD_READY));
      end
    end
  end

endmodule

// File: rtl/ppcpu_hazard_unit.sv
// Interlock, forwarding and flush controller sitting beside ID; tracks in-flight writers
// in a registered scoreboard indexed by stage distance.
module ppcpu_hazard_unit
  import ppcpu_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DFLT,
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned BR_STAGE   = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SEL_W      = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_regwr,
  input  logic              id_load,
  input  logic              id_valid,
  input  logic              redirect,
  input  logic              wb_kill,
  input  logic              clr_cnt,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic [BR_STAGE-1:0] flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t [NSTAGE:1] sb_q, sb_d, sb_view;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [SEL_W-1:0]     sel_a, sel_b;
  logic                 hit_a, hit_b;

  // A killed WB write must not be forwarded.
  always_comb begin
    sb_view                = sb_q;
    sb_view[NSTAGE].regwr  = sb_q[NSTAGE].regwr & ~wb_kill;
  end

  ppcpu_sb_match #(
    .NSTAGE     (NSTAGE),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_rs (
    .src_i      (id_rs),
    .use_i      (id_use_rs),
    .id_valid_i (id_valid),
    .ent_i      (sb_view),
    .fwd_o      (sel_a),
    .load_hit_o (hit_a)
  );

  ppcpu_sb_match #(
    .NSTAGE     (NSTAGE),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_rt (
    .src_i      (id_rt),
    .use_i      (id_use_rt),
    .id_valid_i (id_valid),
    .ent_i      (sb_view),
    .fwd_o      (sel_b),
    .load_hit_o (hit_b)
  );

  always_comb begin
    stall  = ~redirect & (hit_a | hit_b);
    bubble = stall;
    fwd_a  = stall ? SEL_W'(FWD_RF) : sel_a;
    fwd_b  = stall ? SEL_W'(FWD_RF) : sel_b;
    // Gated so flush reads zero while reset is asserted.
    flush  = {BR_STAGE{redirect & Rst_n}};
  end

  always_comb begin
    sb_d = '0;
    for (int d = 2; d <= int'(NSTAGE); d++) begin
      sb_d[d] = sb_q[d-1];
    end
    if (id_valid && !stall && !redirect) begin
      sb_d[D_EX] = '{valid: 1'b1, rw: id_rw, regwr: id_regwr, load: id_load};
    end
    if (redirect) begin
      for (int d = 1; d < int'(BR_STAGE); d++) begin
        if (d <= int'(NSTAGE)) sb_d[d].valid = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ppcpu_hazard_unit.sv
// Self-checking bench for ppcpu_hazard_unit: directed scenarios plus randomized traffic
// checked against an in-flight instruction list model.
module tb_ppcpu_hazard_unit;

  localparam int NSTAGE     = 3;
  localparam int LOAD_READY = 2;
  localparam int BR_STAGE   = 2;
  localparam int CNT_W      = 10;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, id_rw = '0;
  logic             id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwr = 1'b0, id_load = 1'b0;
  logic             id_valid = 1'b0, redirect = 1'b0, wb_kill = 1'b0, clr_cnt = 1'b0;
  logic [1:0]       fwd_a, fwd_b, flush;
  logic             stall, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ppcpu_hazard_unit #(
    .REG_AW     (5),
    .NSTAGE     (NSTAGE),
    .LOAD_READY (LOAD_READY),
    .BR_STAGE   (BR_STAGE),
    .CNT_W      (CNT_W),
    .SEL_W      (2)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_rw     (id_rw),
    .id_regwr  (id_regwr),
    .id_load   (id_load),
    .id_valid  (id_valid),
    .redirect  (redirect),
    .wb_kill   (wb_kill),
    .clr_cnt   (clr_cnt),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall),
    .bubble    (bubble),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 Clk = ~Clk;

  // Reference model: pipe[i] is the instruction i+1 stages past ID.
  typedef struct {
    bit valid;
    int rw;
    bit regwr;
    bit load;
  } inst_t;

  inst_t pipe[$];
  int    m_stall_cnt, m_flush_cnt;

  function automatic void model_reset();
    inst_t e = '{valid: 0, rw: 0, regwr: 0, load: 0};
    pipe.delete();
    for (int i = 0; i < NSTAGE; i++) pipe.push_back(e);
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  function automatic int producer(logic [4:0] src, logic use_src);
    if (!use_src || src == 0 || !id_valid) return 0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].valid && pipe[i].regwr && pipe[i].rw == int'(src) &&
          !((i + 1 == NSTAGE) && wb_kill))
        return i + 1;
    end
    return 0;
  endfunction

  function automatic bit load_wait(int d);
    return (d != 0) && pipe[d-1].load && (d < LOAD_READY);
  endfunction

  function automatic bit exp_stall();
    return !redirect && (load_wait(producer(id_rs, id_use_rs)) ||
                         load_wait(producer(id_rt, id_use_rt)));
  endfunction

  function automatic logic [7:0] exp_outs();
    bit st = exp_stall();
    int fa = st ? 0 : producer(id_rs, id_use_rs);
    int fb = st ? 0 : producer(id_rt, id_use_rt);
    return {2'(fa), 2'(fb), st, st, {2{redirect}}};
  endfunction

  // Advance model and DUT by one clock; inputs are sampled as they stand before the edge.
  task automatic tick();
    bit    st = exp_stall();
    bit    r  = redirect;
    inst_t n  = '{valid: 0, rw: 0, regwr: 0, load: 0};
    if (id_valid && !st && !redirect)
      n = '{valid: 1, rw: int'(id_rw), regwr: id_regwr, load: id_load};
    if (clr_cnt) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (st && m_stall_cnt < CMAX) m_stall_cnt++;
      if (r && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    @(posedge Clk);
    pipe.push_front(n);
    while (pipe.size() > NSTAGE) void'(pipe.pop_back());
    if (r) for (int i = 1; i < BR_STAGE; i++) pipe[i-1].valid = 0;
    #1;
  endtask

  task automatic set_inst(bit v, int rs, bit urs, int rt, bit urt, int rw, bit wr, bit ld);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_use_rs = urs;
    id_rt     = 5'(rt);
    id_use_rt = urt;
    id_rw     = 5'(rw);
    id_regwr  = wr;
    id_load   = ld;
  endtask

  task automatic idle(int n);
    set_inst(0, 0, 0, 0, 0, 0, 0, 0);
    redirect = 0;
    wb_kill  = 0;
    clr_cnt  = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counters();
    clr_cnt = 1;
    tick();
    clr_cnt = 0;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_outputs: got %b want all zero",
               {fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt});
    else pass_cnt++;
    @(posedge Clk);
    #1;
    Rst_n = 1;
    model_reset();
  endtask

  task automatic test_alu_fwd();
    idle(3);
    set_inst(1, 1, 1, 2, 1, 3, 1, 0);  // add $3,$1,$2
    #1;
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL alu_first_stall: got %b want 0", stall);
    else pass_cnt++;
    tick();
    set_inst(1, 3, 1, 5, 1, 4, 1, 0);  // sub $4,$3,$5
    #1;
    chk_cnt++;
    if ({fwd_a, stall} !== {2'd1, 1'b0})
      $display("FAIL alu_fwd_ex: got fwd_a=%0d stall=%b want fwd_a=1 stall=0", fwd_a, stall);
    else pass_cnt++;
    tick();
    set_inst(1, 1, 1, 3, 1, 9, 1, 0);  // and $9,$1,$3
    #1;
    chk_cnt++;
    if ({fwd_a, fwd_b, stall} !== {2'd0, 2'd2, 1'b0})
      $display("FAIL alu_fwd_mem: got fwd_a=%0d fwd_b=%0d stall=%b want 0 2 0",
               fwd_a, fwd_b, stall);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_use();
    idle(3);
    clear_counters();
    set_inst(1, 29, 1, 0, 0, 2, 1, 1);  // lw $2,0($29)
    #1;
    tick();
    set_inst(1, 2, 1, 7, 1, 6, 1, 0);   // add $6,$2,$7
    #1;
    chk_cnt++;
    if ({stall, bubble, fwd_a} !== {1'b1, 1'b1, 2'd0})
      $display("FAIL load_use_stall: got stall=%b bubble=%b fwd_a=%0d want 1 1 0",
               stall, bubble, fwd_a);
    else pass_cnt++;
    tick();
    #1;
    chk_cnt++;
    if ({stall, bubble, fwd_a, stall_cnt} !== {1'b0, 1'b0, 2'd2, CNT_W'(1)})
      $display("FAIL load_use_release: got stall=%b bubble=%b fwd_a=%0d cnt=%0d want 0 0 2 1",
               stall, bubble, fwd_a, stall_cnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reg0();
    idle(3);
    set_inst(1, 1, 1, 0, 0, 0, 1, 1);  // lw $0,0($1)
    #1;
    tick();
    set_inst(1, 0, 1, 0, 1, 4, 1, 0);  // add $4,$0,$0
    #1;
    chk_cnt++;
    if ({fwd_a, fwd_b, stall, bubble} !== 6'b0)
      $display("FAIL reg0: got fwd_a=%0d fwd_b=%0d stall=%b bubble=%b want all 0",
               fwd_a, fwd_b, stall, bubble);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_youngest_wb_kill();
    idle(3);
    set_inst(1, 1, 1, 2, 1, 8, 1, 0);
    tick();
    set_inst(1, 1, 1, 2, 1, 9, 0, 0);  // store-like, no write
    tick();
    set_inst(1, 3, 1, 4, 1, 8, 1, 0);
    tick();
    set_inst(1, 8, 1, 0, 0, 10, 1, 0);
    #1;
    chk_cnt++;
    if (fwd_a !== 2'd1) $display("FAIL youngest_wins: got %0d want 1", fwd_a);
    else pass_cnt++;
    idle(3);
    set_inst(1, 1, 1, 2, 1, 8, 1, 0);
    tick();
    idle(2);
    set_inst(1, 0, 0, 8, 1, 10, 1, 0);
    #1;
    chk_cnt++;
    if (fwd_b !== 2'd3) $display("FAIL wb_fwd: got %0d want 3", fwd_b);
    else pass_cnt++;
    wb_kill = 1;
    #1;
    chk_cnt++;
    if (fwd_b !== 2'd0) $display("FAIL wb_kill: got %0d want 0", fwd_b);
    else pass_cnt++;
    wb_kill = 0;
    tick();
  endtask

  task automatic test_redirect();
    idle(3);
    clear_counters();
    set_inst(1, 29, 1, 0, 0, 2, 1, 1);  // lw $2
    tick();
    set_inst(1, 2, 1, 0, 0, 2, 1, 1);   // lw $2,0($2) with redirect
    redirect = 1;
    #1;
    chk_cnt++;
    if ({flush, stall, bubble} !== {2'b11, 1'b0, 1'b0})
      $display("FAIL redirect_same_cycle: got flush=%b stall=%b bubble=%b want 11 0 0",
               flush, stall, bubble);
    else pass_cnt++;
    tick();
    redirect = 0;
    set_inst(1, 2, 1, 0, 0, 6, 1, 0);
    #1;
    chk_cnt++;
    if ({flush, stall, fwd_a, flush_cnt, stall_cnt} !== {2'b00, 1'b0, 2'd2, CNT_W'(1), CNT_W'(0)})
      $display("FAIL redirect_after: got flush=%b stall=%b fwd_a=%0d fcnt=%0d scnt=%0d want 00 0 2 1 0",
               flush, stall, fwd_a, flush_cnt, stall_cnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] e;
    idle(3);
    for (int c = 0; c < 400; c++) begin
      set_inst($urandom_range(9, 0) < 8, $urandom_range(7, 0), $urandom_range(1, 0),
               $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
               $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0);
      redirect = $urandom_range(9, 0) == 0;
      wb_kill  = $urandom_range(9, 0) == 0;
      clr_cnt  = $urandom_range(49, 0) == 0;
      #1;
      e = exp_outs();
      chk_cnt++;
      if ({fwd_a, fwd_b, stall, bubble, flush} !== e)
        $display("FAIL random_outs cycle %0d: got %b want %b", c,
                 {fwd_a, fwd_b, stall, bubble, flush}, e);
      else pass_cnt++;
      chk_cnt++;
      if ({stall_cnt, flush_cnt} !== {CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt)})
        $display("FAIL random_cnt cycle %0d: got %0d/%0d want %0d/%0d", c,
                 stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_saturation_and_reset();
    idle(3);
    clear_counters();
    set_inst(1, 2, 1, 0, 0, 2, 1, 1);  // lw $2,0($2): stalls every other cycle
    for (int i = 0; i < 2 * (CMAX + 4); i++) tick();
    chk_cnt++;
    if (stall_cnt !== CNT_W'(CMAX)) $display("FAIL stall_sat: got %0d want %0d", stall_cnt, CMAX);
    else pass_cnt++;
    clear_counters();
    chk_cnt++;
    if (stall_cnt !== '0) $display("FAIL stall_clr: got %0d want 0", stall_cnt);
    else pass_cnt++;
    idle(3);
    set_inst(1, 2, 1, 0, 0, 2, 1, 1);
    tick();  // accepted
    tick();  // stalled, counted
    tick();  // accepted again; load now at distance 1
    chk_cnt++;
    if ({stall, stall_cnt} !== {1'b1, CNT_W'(1)})
      $display("FAIL pre_reset_stall: got stall=%b cnt=%0d want 1 1", stall, stall_cnt);
    else pass_cnt++;
    #2;
    Rst_n = 0;
    #1;
    chk_cnt++;
    if ({fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt} !== '0)
      $display("FAIL async_reset: got %b want all zero",
               {fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt});
    else pass_cnt++;
    @(posedge Clk);
    #1;
    Rst_n = 1;
    model_reset();
    #1;
    chk_cnt++;
    if ({fwd_a, stall} !== {2'd0, 1'b0})
      $display("FAIL post_reset_empty: got fwd_a=%0d stall=%b want 0 0", fwd_a, stall);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_reg0();
    test_youngest_wb_kill();
    test_redirect();
    test_random();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
